// File: rtl/io_port.sv
// io_port: word-level I/O bridge between the CPU core and an external host.
// Host words are buffered in an input FIFO that the CPU reads through
// cpu_in/cpu_control. CPU words are captured into an output FIFO that drains
// to the host over a valid/ready handshake. The CPU is never stalled. If it
// strobes a word while the output FIFO is full, the word is dropped.
// Optional feature: define IO_PORT_DROP_CNT_EN to build a saturating counter
// of dropped CPU words on drop_cnt. Without the macro, drop_cnt is tied to 0.

// Circular FIFO with combinational head read from registered storage.
// The caller qualifies push with not_full and pop with not_empty.
module io_port_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  not_empty,
    output logic                  not_full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [PTR_W:0]        count_reg;

    // Storage is deliberately left out of reset; only the bookkeeping is cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    // Push and pop together leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    assign rd_data   = mem_reg[rd_ptr_reg];
    assign not_empty = (count_reg != '0);
    assign not_full  = (count_reg != FULL_CNT);
endmodule

module io_port #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  host_in_valid,
    output logic                  host_in_ready,
    input  logic [DATA_WIDTH-1:0] host_in_data,
    output logic [DATA_WIDTH-1:0] cpu_in,
    output logic                  cpu_control,
    input  logic                  cpu_in_ack,
    input  logic [DATA_WIDTH-1:0] cpu_out,
    input  logic                  cpu_out_valid,
    output logic                  host_out_valid,
    input  logic                  host_out_ready,
    output logic [DATA_WIDTH-1:0] host_out_data,
    output logic [7:0]            drop_cnt
);
    // Index 0 is the host-to-CPU FIFO. Index 1 is the CPU-to-host FIFO.
    logic [1:0]            fifo_push;
    logic [1:0]            fifo_pop;
    logic [1:0]            fifo_not_empty;
    logic [1:0]            fifo_not_full;
    logic [DATA_WIDTH-1:0] fifo_wr_data [2];
    logic [DATA_WIDTH-1:0] fifo_rd_data [2];

    assign fifo_wr_data[0] = host_in_data;
    assign fifo_wr_data[1] = cpu_out;

    // Fullness and emptiness come from pre-edge counts. As a result, a strobe
    // into a full output FIFO is a drop, even when the host pops that cycle.
    assign fifo_push[0] = host_in_valid & fifo_not_full[0];
    assign fifo_pop[0]  = cpu_in_ack & fifo_not_empty[0];
    assign fifo_push[1] = cpu_out_valid & fifo_not_full[1];
    assign fifo_pop[1]  = host_out_ready & fifo_not_empty[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            io_port_fifo #(
                .DATA_WIDTH(DATA_WIDTH),
                .DEPTH     (DEPTH)
            ) u_fifo (
                .clk      (clk),
                .rst_n    (rst_n),
                .push     (fifo_push[gi]),
                .pop      (fifo_pop[gi]),
                .wr_data  (fifo_wr_data[gi]),
                .rd_data  (fifo_rd_data[gi]),
                .not_empty(fifo_not_empty[gi]),
                .not_full (fifo_not_full[gi])
            );
        end
    endgenerate

    assign host_in_ready  = fifo_not_full[0];
    assign cpu_control    = fifo_not_empty[0];
    assign cpu_in         = fifo_rd_data[0];
    assign host_out_valid = fifo_not_empty[1];
    assign host_out_data  = fifo_rd_data[1];

`ifdef IO_PORT_DROP_CNT_EN
    logic       drop;
    logic [7:0] drop_cnt_reg;

    assign drop = cpu_out_valid & ~fifo_not_full[1];

    // Saturating count of CPU words lost to a full output FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_reg <= 8'd0;
        end else if (drop && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end

    assign drop_cnt = drop_cnt_reg;
`else
    assign drop_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_io_port.sv
// tb_io_port: table-driven directed test of io_port, plus a hand-written
// asynchronous reset sequence.
module tb_io_port;
`ifdef IO_PORT_DROP_CNT_EN
    localparam int DE = 1;
`else
    localparam int DE = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        host_in_valid;
    logic        host_in_ready;
    logic [15:0] host_in_data;
    logic [15:0] cpu_in;
    logic        cpu_control;
    logic        cpu_in_ack;
    logic [15:0] cpu_out;
    logic        cpu_out_valid;
    logic        host_out_valid;
    logic        host_out_ready;
    logic [15:0] host_out_data;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    io_port #(.DATA_WIDTH(16), .DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .host_in_valid (host_in_valid),
        .host_in_ready (host_in_ready),
        .host_in_data  (host_in_data),
        .cpu_in        (cpu_in),
        .cpu_control   (cpu_control),
        .cpu_in_ack    (cpu_in_ack),
        .cpu_out       (cpu_out),
        .cpu_out_valid (cpu_out_valid),
        .host_out_valid(host_out_valid),
        .host_out_ready(host_out_ready),
        .host_out_data (host_out_data),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hiv;
        logic [15:0] hid;
        logic        ack;
        logic        cov;
        logic [15:0] co;
        logic        hor;
        logic        e_hir;
        logic        e_cc;
        logic [15:0] e_ci;
        logic        e_hov;
        logic [15:0] e_hod;
        logic [7:0]  e_drop;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic hiv, logic [15:0] hid, logic ack,
                                logic cov, logic [15:0] co, logic hor,
                                logic e_hir, logic e_cc, logic [15:0] e_ci,
                                logic e_hov, logic [15:0] e_hod, int e_drop);
        vec_t v;
        v.hiv = hiv; v.hid = hid; v.ack = ack;
        v.cov = cov; v.co = co; v.hor = hor;
        v.e_hir = e_hir; v.e_cc = e_cc; v.e_ci = e_ci;
        v.e_hov = e_hov; v.e_hod = e_hod; v.e_drop = 8'(e_drop);
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic hiv, input logic [15:0] hid, input logic ack,
                         input logic cov, input logic [15:0] co, input logic hor);
        host_in_valid  = hiv;
        host_in_data   = hid;
        cpu_in_ack     = ack;
        cpu_out_valid  = cov;
        cpu_out        = co;
        host_out_ready = hor;
    endtask

    initial begin
        drive(0, 16'h0, 0, 0, 16'h0, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_hir", host_in_ready, 1);
        chk("rst_cc", cpu_control, 0);
        chk("rst_hov", host_out_valid, 0);
        chk("rst_drop", drop_cnt, 0);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Idle
        for (int i = 0; i < 5; i++) add(0,16'h0,0, 0,16'h0,0, 1,0,16'h0, 0,16'h0,0);
        // Fill input FIFO. A held 5th word is refused. Four acks drain it in order.
        add(1,16'h1111,0, 0,16'h0,0, 1,1,16'h1111, 0,16'h0,0);
        add(1,16'h2222,0, 0,16'h0,0, 1,1,16'h1111, 0,16'h0,0);
        add(1,16'h3333,0, 0,16'h0,0, 1,1,16'h1111, 0,16'h0,0);
        add(1,16'h4444,0, 0,16'h0,0, 0,1,16'h1111, 0,16'h0,0);
        add(1,16'h5555,0, 0,16'h0,0, 0,1,16'h1111, 0,16'h0,0);
        add(1,16'h5555,0, 0,16'h0,0, 0,1,16'h1111, 0,16'h0,0);
        add(0,16'h0,1,    0,16'h0,0, 1,1,16'h2222, 0,16'h0,0);
        add(0,16'h0,1,    0,16'h0,0, 1,1,16'h3333, 0,16'h0,0);
        add(0,16'h0,1,    0,16'h0,0, 1,1,16'h4444, 0,16'h0,0);
        add(0,16'h0,1,    0,16'h0,0, 1,0,16'h0,    0,16'h0,0);
        // Simultaneous push and ack with two words held, across the pointer wrap
        add(1,16'hBBBB,0, 0,16'h0,0, 1,1,16'hBBBB, 0,16'h0,0);
        add(1,16'hCCCC,0, 0,16'h0,0, 1,1,16'hBBBB, 0,16'h0,0);
        add(1,16'hDDDD,0, 0,16'h0,0, 1,1,16'hBBBB, 0,16'h0,0);
        add(0,16'h0,1,    0,16'h0,0, 1,1,16'hCCCC, 0,16'h0,0);
        add(0,16'h0,1,    0,16'h0,0, 1,1,16'hDDDD, 0,16'h0,0);
        add(1,16'hEEEE,0, 0,16'h0,0, 1,1,16'hDDDD, 0,16'h0,0);
        add(1,16'hAAAA,1, 0,16'h0,0, 1,1,16'hEEEE, 0,16'h0,0);
        add(0,16'h0,1,    0,16'h0,0, 1,1,16'hAAAA, 0,16'h0,0);
        add(0,16'h0,1,    0,16'h0,0, 1,0,16'h0,    0,16'h0,0);
        // Six CPU strobes into a stalled output FIFO. The last two are dropped.
        add(0,16'h0,0, 1,16'h0001,0, 1,0,16'h0, 1,16'h0001,0);
        add(0,16'h0,0, 1,16'h0002,0, 1,0,16'h0, 1,16'h0001,0);
        add(0,16'h0,0, 1,16'h0003,0, 1,0,16'h0, 1,16'h0001,0);
        add(0,16'h0,0, 1,16'h0004,0, 1,0,16'h0, 1,16'h0001,0);
        add(0,16'h0,0, 1,16'h0005,0, 1,0,16'h0, 1,16'h0001,DE);
        add(0,16'h0,0, 1,16'h0006,0, 1,0,16'h0, 1,16'h0001,2*DE);
        add(0,16'h0,0, 0,16'h0,1,    1,0,16'h0, 1,16'h0002,2*DE);
        add(0,16'h0,0, 0,16'h0,1,    1,0,16'h0, 1,16'h0003,2*DE);
        add(0,16'h0,0, 0,16'h0,1,    1,0,16'h0, 1,16'h0004,2*DE);
        add(0,16'h0,0, 0,16'h0,1,    1,0,16'h0, 0,16'h0,2*DE);
        // Refill. A strobe on a full FIFO while the host pops is still a drop.
        add(0,16'h0,0, 1,16'h0010,0, 1,0,16'h0, 1,16'h0010,2*DE);
        add(0,16'h0,0, 1,16'h0011,0, 1,0,16'h0, 1,16'h0010,2*DE);
        add(0,16'h0,0, 1,16'h0012,0, 1,0,16'h0, 1,16'h0010,2*DE);
        add(0,16'h0,0, 1,16'h0013,0, 1,0,16'h0, 1,16'h0010,2*DE);
        add(0,16'h0,0, 1,16'h00FF,1, 1,0,16'h0, 1,16'h0011,3*DE);
        add(0,16'h0,0, 0,16'h0,1,    1,0,16'h0, 1,16'h0012,3*DE);
        add(0,16'h0,0, 0,16'h0,1,    1,0,16'h0, 1,16'h0013,3*DE);
        add(0,16'h0,0, 0,16'h0,1,    1,0,16'h0, 0,16'h0,3*DE);

        foreach (vecs[i]) begin
            drive(vecs[i].hiv, vecs[i].hid, vecs[i].ack, vecs[i].cov, vecs[i].co, vecs[i].hor);
            @(posedge clk); #1;
            $display("vec %0d: hir=%0b cc=%0b cpu_in=%h hov=%0b hod=%h drop=%0d",
                     i, host_in_ready, cpu_control, cpu_in, host_out_valid, host_out_data, drop_cnt);
            chk($sformatf("v%0d_hir", i), host_in_ready, vecs[i].e_hir);
            chk($sformatf("v%0d_cc", i), cpu_control, vecs[i].e_cc);
            if (vecs[i].e_cc) chk($sformatf("v%0d_cpu_in", i), cpu_in, vecs[i].e_ci);
            chk($sformatf("v%0d_hov", i), host_out_valid, vecs[i].e_hov);
            if (vecs[i].e_hov) chk($sformatf("v%0d_hod", i), host_out_data, vecs[i].e_hod);
            chk($sformatf("v%0d_drop", i), drop_cnt, vecs[i].e_drop);
        end

        // Asynchronous reset with both FIFOs partly full
        drive(1, 16'h1234, 0, 1, 16'h0ABC, 0);
        @(posedge clk); #1;
        drive(1, 16'h5678, 0, 1, 16'h0DEF, 0);
        @(posedge clk); #1;
        drive(0, 16'h0, 0, 0, 16'h0, 0);
        chk("pre_rst_cc", cpu_control, 1);
        chk("pre_rst_hov", host_out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: hir=%0b cc=%0b hov=%0b drop=%0d",
                 host_in_ready, cpu_control, host_out_valid, drop_cnt);
        chk("arst_cc", cpu_control, 0);
        chk("arst_hov", host_out_valid, 0);
        chk("arst_hir", host_in_ready, 1);
        chk("arst_drop", drop_cnt, 0);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            $display("post reset idle %0d: cc=%0b hov=%0b", i, cpu_control, host_out_valid);
            chk($sformatf("post_rst%0d_cc", i), cpu_control, 0);
            chk($sformatf("post_rst%0d_hov", i), host_out_valid, 0);
        end
        drive(1, 16'h7777, 0, 1, 16'h0077, 0);
        @(posedge clk); #1;
        $display("fresh word: cpu_in=%h hod=%h", cpu_in, host_out_data);
        chk("fresh_cc", cpu_control, 1);
        chk("fresh_cpu_in", cpu_in, 16'h7777);
        chk("fresh_hov", host_out_valid, 1);
        chk("fresh_hod", host_out_data, 16'h0077);
        drive(0, 16'h0, 1, 0, 16'h0, 1);
        @(posedge clk); #1;
        $display("final drain: cc=%0b hov=%0b", cpu_control, host_out_valid);
        chk("final_cc", cpu_control, 0);
        chk("final_hov", host_out_valid, 0);
        drive(0, 16'h0, 0, 0, 16'h0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
